// File: rtl/divisor_rest_pkg.sv
// divisor_rest_pkg
//   Shared definitions for the restoring divider: FSM state encodings,
//   the iteration count and the counter width. Imported by every file of
//   the block so that the encodings and the count live in one place.
package divisor_rest_pkg;

  localparam int ITERS = 8;  // one quotient bit per CALC cycle
  localparam int CNT_W = 4;  // wide enough to hold ITERS

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/divisor_rest_if.sv
// divisor_rest_if
//   Request/result bundle of the divider.
//   master : drives start/initD/initV, observes results (testbench side)
//   slave  : the divider itself
//   start    - request a division (sampled on clk rising edge)
//   initD    - 8-bit two's-complement dividend
//   initV    - 4-bit two's-complement divisor
//   cociente - 4-bit two's-complement quotient
//   resto    - 4-bit two's-complement remainder (sign of dividend)
//   fin      - result valid, held until next accepted start or reset
//   error    - divide-by-zero or quotient overflow, valid with fin
interface divisor_rest_if;
  logic       start;
  logic [7:0] initD;
  logic [3:0] initV;
  logic [3:0] cociente;
  logic [3:0] resto;
  logic       fin;
  logic       error;

  modport master (output start, initD, initV,
                  input  cociente, resto, fin, error);
  modport slave  (input  start, initD, initV,
                  output cociente, resto, fin, error);
endinterface

// File: rtl/divisor_rest_ca2.sv
// ca2
//   Conditional two's-complement negation.
//   a   - W-bit operand
//   neg - 1: y = -a, 0: y = a
//   y   - W-bit result
module ca2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~a + W'(1)) : a;
endmodule

// File: rtl/divisor_rest.sv
// divisor_rest
//   Signed 8-bit / 4-bit restoring divider. Works on magnitudes for eight
//   CALC cycles, then fixes up the signs in FIX. Remainder takes the sign
//   of the dividend. A zero divisor skips CALC and reports error one edge
//   after the accepting edge; a quotient outside -8..+7 reports error.
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - divisor_rest_if slave (start/initD/initV in, results out)
module divisor_rest
  import divisor_rest_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  divisor_rest_if.slave  bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rem;     // partial remainder magnitude, always < |V| <= 8
  logic [7:0]       dq;      // dividend bits shift out the top, quotient bits in the bottom
  logic [4:0]       mag_v;
  logic             sgn_d, sgn_v, v_zero;

  logic [8:0] abs_d;
  logic [4:0] abs_v;
  logic [7:0] q_signed;
  logic [4:0] r_signed;
  logic [4:0] r_sh;
  logic [5:0] diff;
  logic       neg_q, ovf, accept;

  // Magnitudes of the operands; |-128| needs the ninth bit, |-8| the fifth.
  ca2 #(.W(9)) u_abs_d (.a({bus.initD[7], bus.initD}), .neg(bus.initD[7]), .y(abs_d));
  ca2 #(.W(5)) u_abs_v (.a({bus.initV[3], bus.initV}), .neg(bus.initV[3]), .y(abs_v));
  // Sign correction of the results.
  ca2 #(.W(8)) u_sgn_q (.a(dq),  .neg(neg_q), .y(q_signed));
  ca2 #(.W(5)) u_sgn_r (.a(rem), .neg(sgn_d), .y(r_signed));

  // abs_d[8] is always 0 (max magnitude 128); upper result bits are only
  // meaningful through the overflow test on the magnitude.
  logic unused_bits;
  assign unused_bits = ^{abs_d[8], q_signed[7:4], r_signed[4]};

  assign neg_q  = sgn_d ^ sgn_v;
  // -8 is representable, +8 is not.
  assign ovf    = neg_q ? (dq > 8'd8) : (dq > 8'd7);
  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  assign r_sh = {rem[3:0], dq[7]};
  assign diff = {1'b0, r_sh} - {1'b0, mag_v};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = (bus.initV == 4'd0) ? FIX : CALC;
      CALC:       if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      rem          <= '0;
      dq           <= '0;
      mag_v        <= '0;
      sgn_d        <= 1'b0;
      sgn_v        <= 1'b0;
      v_zero       <= 1'b0;
      bus.cociente <= '0;
      bus.resto    <= '0;
      bus.fin      <= 1'b0;
      bus.error    <= 1'b0;
    end else begin
      if (accept) begin
        sgn_d     <= bus.initD[7];
        sgn_v     <= bus.initV[3];
        mag_v     <= abs_v;
        dq        <= abs_d[7:0];
        rem       <= '0;
        v_zero    <= (bus.initV == 4'd0);
        // Zero divisor goes straight to FIX, so the counter is not needed.
        cnt       <= (bus.initV == 4'd0) ? '0 : CNT_W'(ITERS);
        bus.fin   <= 1'b0;
        bus.error <= 1'b0;
      end else if (state == CALC) begin
        if (diff[5]) begin
          rem <= r_sh;
          dq  <= {dq[6:0], 1'b0};
        end else begin
          rem <= diff[4:0];
          dq  <= {dq[6:0], 1'b1};
        end
        cnt <= cnt - CNT_W'(1);
      end else if (state == FIX) begin
        bus.fin <= 1'b1;
        if (v_zero || ovf) begin
          bus.error    <= 1'b1;
          bus.cociente <= '0;
          bus.resto    <= '0;
        end else begin
          bus.error    <= 1'b0;
          bus.cociente <= q_signed[3:0];
          bus.resto    <= r_signed[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_divisor_rest.sv
module tb_divisor_rest;

  logic clk, rst;
  divisor_rest_if bus ();

  divisor_rest dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic [3:0] v;
    logic [3:0] q;
    logic [3:0] r;
    logic       e;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts edges (sampled at negedge) until fin is seen; -1 if it never comes.
  task automatic wait_fin(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.fin === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic chk_res(input string name, input logic [3:0] q, input logic [3:0] r, input logic e);
    chk({name, ".q"}, {4'h0, bus.cociente}, {4'h0, q});
    chk({name, ".r"}, {4'h0, bus.resto},    {4'h0, r});
    chk({name, ".e"}, {7'h0, bus.error},    {7'h0, e});
  endtask

  // Called at a negedge; the next posedge is the accepting edge N.
  task automatic do_div(input string name, input vec_t t);
    int lat;
    bus.start = 1'b1;
    bus.initD = t.d;
    bus.initV = t.v;
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, ".fin_clr"}, {7'h0, bus.fin}, 8'h0);
    wait_fin(lat);
    chk_int({name, ".lat"}, lat, t.lat);
    chk_res(name, t.q, t.r, t.e);
  endtask

  vec_t tv[12];
  int   lat;

  initial begin
    //          d       v      q      r      e    lat
    tv[0]  = '{8'h17, 4'h5, 4'h4, 4'h3, 1'b0, 9}; //  23 /  5 =  4 r  3
    tv[1]  = '{8'hE9, 4'h5, 4'hC, 4'hD, 1'b0, 9}; // -23 /  5 = -4 r -3
    tv[2]  = '{8'hD3, 4'h9, 4'h6, 4'hD, 1'b0, 9}; // -45 / -7 =  6 r -3
    tv[3]  = '{8'h17, 4'h0, 4'h0, 4'h0, 1'b1, 1}; // divide by zero
    tv[4]  = '{8'h40, 4'h2, 4'h0, 4'h0, 1'b1, 9}; //  64 /  2 = 32 overflow
    tv[5]  = '{8'hF0, 4'h2, 4'h8, 4'h0, 1'b0, 9}; // -16 /  2 = -8 legal
    tv[6]  = '{8'h07, 4'hE, 4'hD, 4'h1, 1'b0, 9}; //   7 / -2 = -3 r  1
    tv[7]  = '{8'h80, 4'h8, 4'h0, 4'h0, 1'b1, 9}; // -128/ -8 = 16 overflow
    tv[8]  = '{8'h80, 4'hF, 4'h0, 4'h0, 1'b1, 9}; // -128/ -1 = 128 overflow
    tv[9]  = '{8'hF8, 4'h1, 4'h8, 4'h0, 1'b0, 9}; //  -8 /  1 = -8
    tv[10] = '{8'hF9, 4'h8, 4'h0, 4'h9, 1'b0, 9}; //  -7 / -8 =  0 r -7
    tv[11] = '{8'h0F, 4'h8, 4'hF, 4'h7, 1'b0, 9}; //  15 / -8 = -1 r  7

    rst = 1'b1;
    bus.start = 1'b1;  // must be overridden by reset
    bus.initD = 8'h17;
    bus.initV = 4'h5;
    repeat (3) @(negedge clk);
    chk("rst.fin", {7'h0, bus.fin}, 8'h0);
    chk_res("rst", 4'h0, 4'h0, 1'b0);

    // Start accepted at the first edge after reset deasserts.
    rst = 1'b0;
    for (int i = 0; i < 12; i++) do_div($sformatf("vec%0d", i), tv[i]);

    // Start pulsed during CALC is ignored.
    bus.start = 1'b1; bus.initD = 8'h17; bus.initV = 4'h5;
    @(negedge clk);                        // N
    bus.start = 1'b0;
    repeat (2) @(negedge clk);             // N+1, N+2
    bus.start = 1'b1; bus.initD = 8'h40; bus.initV = 4'h2;
    @(negedge clk);                        // N+3
    bus.start = 1'b0;
    wait_fin(lat);
    chk_int("ign.lat", lat, 6);
    chk_res("ign", 4'h4, 4'h3, 1'b0);

    // Outputs hold in DONE while operands change.
    bus.initD = 8'hFF; bus.initV = 4'h1;
    repeat (3) @(negedge clk);
    chk("hold.fin", {7'h0, bus.fin}, 8'h1);
    chk_res("hold", 4'h4, 4'h3, 1'b0);

    // Reset on the 4th CALC edge, then restart two edges later.
    bus.start = 1'b1; bus.initD = 8'hE9; bus.initV = 4'h5;
    @(negedge clk);                        // N
    bus.start = 1'b0;
    repeat (3) @(negedge clk);             // N+1..N+3
    rst = 1'b1;
    @(negedge clk);                        // N+4 (reset edge R)
    rst = 1'b0;
    chk("mrst.fin", {7'h0, bus.fin}, 8'h0);
    chk_res("mrst", 4'h0, 4'h0, 1'b0);
    @(negedge clk);                        // R+1
    chk("mrst.fin2", {7'h0, bus.fin}, 8'h0);
    do_div("restart", '{8'h17, 4'h5, 4'h4, 4'h3, 1'b0, 9});

    // Start in DONE with new operands.
    do_div("redo", '{8'hE9, 4'h5, 4'hC, 4'hD, 1'b0, 9});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
